multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Phase sequencer for the multi-cycle core. It replaces the fixed two-clock scheme (processor clock plus a delayed data-memory clock) with one clock and a phase FSM.
- Generates per-phase write enables and memory strobes. Supports variable-latency instruction/data memories via ready handshakes, free-run and single-step modes, a memory timeout fault, and cycle/retired-instruction counters.
- Sits between the ROM control decoder and the datapath (PC register, IR, register file, data memory).

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt
- TIMEOUT, 16, max cycles FETCH or MEM may wait for its ready before fault; range 1..255

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  level; 1 = free-run instructions back-to-back
- step  in  1  one-cycle pulse; executes one instruction when run=0
- imem_ready  in  1  instruction memory has valid inst this cycle
- dmem_ready  in  1  data memory completes access this cycle
- dec_load  in  1  decoded instruction is a load (valid from DECODE on)
- dec_store  in  1  decoded instruction is a store (valid from DECODE on)
- dec_regwrite  in  1  decoded instruction writes rd
- imem_req  out  1  fetch request
- ir_we  out  1  latch instruction register
- dmem_re  out  1  data read strobe
- dmem_we  out  1  data write strobe
- reg_we  out  1  register file write enable
- pc_we  out  1  PC register update
- phase  out  3  current state encoding
- busy  out  1  1 when state not IDLE/HALT
- fault  out  1  sticky memory-timeout flag
- cycle_cnt  out  CNT_W  busy cycles since reset
- instret_cnt  out  CNT_W  retired instructions since reset

Behaviour:
- States and phase codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- All outputs are combinational from state and inputs, except the registered fault and counters.
- Reset (any state, any cycle, including mid-MEM): state IDLE; all strobes 0; fault=0; counters=0. An in-flight access is abandoned; no reg_we or pc_we is issued.
- IDLE: if run=1 go to FETCH with step_mode=0. Else if step=1 go to FETCH with step_mode=1. Else stay.
- FETCH:
  - imem_req=1 every cycle.
  - ir_we=1 only in the cycle imem_ready=1; next state is DECODE.
  - Wait counter starts at 0 on entry and increments each cycle imem_ready=0. When it reaches TIMEOUT, go to HALT.
- DECODE: exactly 1 cycle, no strobes; go to EXEC.
- EXEC: exactly 1 cycle; go to MEM if dec_load|dec_store, else WB.
- MEM:
  - Load: dmem_re=1 each cycle. Store: dmem_we=1 each cycle.
  - Strobes are held until dmem_ready=1; that cycle commits the access, then go to WB.
  - If dec_load and dec_store are both 1, treat as load; dmem_we=0.
  - Same TIMEOUT rule as FETCH, counted from MEM entry.
- WB: exactly 1 cycle.
  - pc_we=1; reg_we=dec_regwrite; instret_cnt+1.
  - Next state: FETCH if run=1 and step_mode=0, else IDLE.
- HALT: fault=1, all strobes 0. Stays in HALT until rst. run and step are ignored.
- run deasserted mid-instruction: the current instruction completes through WB, then IDLE.
- step while run=1 or while busy: ignored.
- run asserted during a step-mode instruction: takes effect only from IDLE.
- cycle_cnt increments every cycle busy=1. Both counters wrap modulo 2^CNT_W with no saturation.
- Latency with ready tied high:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles plus (dmem_ready delay).
- At most one of ir_we, dmem_re, dmem_we, pc_we is high in any cycle. reg_we is high only together with pc_we.

Test Plan:
- rst 2 cycles, run=1, both readies=1, dec_*=0/0/1 for 3 instructions -> phase 1,2,3,5 repeating; pc_we every 4th cycle; instret_cnt=3 and cycle_cnt=12 after 12 busy cycles.
- Load, dmem_ready low 3 MEM cycles then high -> dmem_re high for 4 cycles; WB with reg_we=1; total 8 cycles from FETCH.
- Store, dec_regwrite=0 -> dmem_we high until ready; reg_we=0 in WB; dmem_re never high; load+store both 1 -> dmem_we stays 0.
- run=0, step pulse once -> exactly one instruction, then phase=0 and busy=0; second step pulse while busy -> ignored (instret_cnt+1 only).
- dmem_ready held 0 with TIMEOUT=16 -> HALT after 16 MEM cycles; fault=1; run toggles ignored; rst -> IDLE, fault=0.
- rst asserted in 2nd MEM cycle of a store -> next cycle phase=0, dmem_we=0, no pc_we/reg_we; counters=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Single-clock phase sequencer for the multi-cycle core.
// Drives per-phase strobes, handles memory ready waits, timeout fault and counters.
module multicycle_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_regwrite,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic [7:0]       wait_q, wait_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             timed_out;

  assign timed_out = (wait_q == WAIT_LIM);

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    wait_d      = wait_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
          wait_d  = '0;
        end else if (timed_out) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wait_d  = '0;
        state_d = (dec_load || dec_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // A load wins when both decode flags are set
        dmem_re = dec_load;
        dmem_we = dec_store && !dec_load;
        if (dmem_ready) begin
          state_d = S_WB;
          wait_d  = '0;
        end else if (timed_out) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        reg_we  = dec_regwrite;
        wait_d  = '0;
        state_d = (run && !step_mode_q) ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset abandons any in-flight access in the same cycle
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
    end
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
  assign phase = state_q;

  always_comb begin
    fault_d   = fault_q || (state_d == S_HALT);
    cycle_d   = cycle_q + CNT_W'(busy);
    instret_d = instret_q + CNT_W'(state_q == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_mode_q <= 1'b0;
      wait_q      <= '0;
      fault_q     <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      wait_q      <= wait_d;
      fault_q     <= fault_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
    end
  end

  assign fault       = fault_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
